// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register feeding decode.
// Handles load-use stall hold, redirect flush, imem wait bubbles and saturating perf counters.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              stall,
   input  logic [1:0]        pcsource,
   input  logic [31:0]       bpc,
   input  logic [31:0]       rpc,
   input  logic [31:0]       jpc,
   output logic [31:0]       imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_ready,
   output logic [31:0]       pc,
   output logic [31:0]       id_pc4,
   output logic [31:0]       id_inst,
   output logic              id_valid,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      id_pc4_q, id_pc4_d;
   logic [31:0]      id_inst_q, id_inst_d;
   logic             id_valid_q, id_valid_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [31:0]      pc4_s;
   logic [31:0]      target_raw_s;
   logic [31:0]      target_s;

   assign pc4_s     = pc_q + 32'd4;
   assign target_s  = {target_raw_s[31:2], 2'b00};
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign id_pc4    = id_pc4_q;
   assign id_inst   = id_inst_q;
   assign id_valid  = id_valid_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   // Redirect target mux; low bits are cleared so fetch stays word-aligned.
   always_comb begin
      target_raw_s = pc4_s;
      case (pcsource)
         2'b01:   target_raw_s = bpc;
         2'b10:   target_raw_s = rpc;
         2'b11:   target_raw_s = jpc;
         default: target_raw_s = pc4_s;
      endcase
   end

   // Next-state: stall > redirect > imem wait > normal fetch.
   always_comb begin
      pc_d        = pc_q;
      id_pc4_d    = id_pc4_q;
      id_inst_d   = id_inst_q;
      id_valid_d  = id_valid_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall) begin
         if (stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
         end else begin
            stall_cnt_d = stall_cnt_q;
         end
      end else if (pcsource != 2'b00) begin
         // Wrong-path word is dropped even if imem has it ready.
         pc_d       = target_s;
         id_pc4_d   = pc4_s;
         id_inst_d  = NOP_INST;
         id_valid_d = 1'b0;
         if (flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
         end else begin
            flush_cnt_d = flush_cnt_q;
         end
      end else if (!imem_ready) begin
         id_inst_d  = NOP_INST;
         id_valid_d = 1'b0;
      end else begin
         pc_d       = pc4_s;
         id_pc4_d   = pc4_s;
         id_inst_d  = imem_rdata;
         id_valid_d = 1'b1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         pc_q        <= RESET_PC;
         id_pc4_q    <= 32'h0000_0000;
         id_inst_q   <= NOP_INST;
         id_valid_q  <= 1'b0;
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         pc_q        <= pc_d;
         id_pc4_q    <= id_pc4_d;
         id_inst_q   <= id_inst_d;
         id_valid_q  <= id_valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage: default instance plus a
// narrow-counter / high-reset-PC instance for saturation and PC wrap.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        clrn, stall;
   logic [1:0]  pcsource;
   logic [31:0] bpc, rpc, jpc;
   logic [31:0] imem_addr, imem_rdata, rdata_fix;
   logic        imem_ready, use_model;
   logic [31:0] pc, id_pc4, id_inst;
   logic        id_valid;
   logic [15:0] stall_cnt, flush_cnt;

   logic        clrn2, stall2;
   logic [31:0] imem_addr2, pc2, id_pc4_2, id_inst2;
   logic        id_valid2;
   logic [1:0]  stall_cnt2, flush_cnt2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign imem_rdata = use_model ? (32'hA000_0000 | imem_addr) : rdata_fix;

   if_fetch_stage u_dut (
      .clk(clk), .clrn(clrn), .stall(stall), .pcsource(pcsource),
      .bpc(bpc), .rpc(rpc), .jpc(jpc),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .pc(pc), .id_pc4(id_pc4), .id_inst(id_inst), .id_valid(id_valid),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) u_dut2 (
      .clk(clk), .clrn(clrn2), .stall(stall2), .pcsource(2'b00),
      .bpc(32'h0000_0000), .rpc(32'h0000_0000), .jpc(32'h0000_0000),
      .imem_addr(imem_addr2), .imem_rdata(32'h5555_0000), .imem_ready(1'b1),
      .pc(pc2), .id_pc4(id_pc4_2), .id_inst(id_inst2), .id_valid(id_valid2),
      .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_main(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pc4,
                             input logic [31:0] e_inst, input logic e_valid);
      check_eq({tag, ".pc"}, pc, e_pc);
      check_eq({tag, ".imem_addr"}, imem_addr, e_pc);
      check_eq({tag, ".id_pc4"}, id_pc4, e_pc4);
      check_eq({tag, ".id_inst"}, id_inst, e_inst);
      check_eq({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, e_valid});
   endtask

   initial begin
      clrn = 1'b0; stall = 1'b0; pcsource = 2'b00;
      bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
      imem_ready = 1'b1; use_model = 1'b1; rdata_fix = 32'h0;
      clrn2 = 1'b0; stall2 = 1'b0;

      step();
      check_main("rst0", 32'h0, 32'h0, 32'h0, 1'b0);
      check_eq("rst0.stall_cnt", {16'd0, stall_cnt}, 32'd0);
      check_eq("rst0.flush_cnt", {16'd0, flush_cnt}, 32'd0);

      // T2 sequential fetch
      clrn = 1'b1; clrn2 = 1'b1;
      step(); check_main("seq1", 32'h4, 32'h4, 32'hA000_0000, 1'b1);
      step(); check_main("seq2", 32'h8, 32'h8, 32'hA000_0004, 1'b1);
      step(); check_main("seq3", 32'hC, 32'hC, 32'hA000_0008, 1'b1);

      // T1 mid-run reset beats simultaneous stall and redirect
      stall = 1'b1;
      step(); check_eq("pre_rst.stall_cnt", {16'd0, stall_cnt}, 32'd1);
      clrn = 1'b0; pcsource = 2'b01; bpc = 32'h200;
      step();
      check_main("rst1", 32'h0, 32'h0, 32'h0, 1'b0);
      check_eq("rst1.stall_cnt", {16'd0, stall_cnt}, 32'd0);
      check_eq("rst1.flush_cnt", {16'd0, flush_cnt}, 32'd0);
      clrn = 1'b1; stall = 1'b0; pcsource = 2'b00;
      step(); step();
      check_main("refetch", 32'h8, 32'h8, 32'hA000_0004, 1'b1);

      // T3 stall ignores pending branch
      stall = 1'b1; pcsource = 2'b01; bpc = 32'h40;
      step(); step();
      check_main("stall", 32'h8, 32'h8, 32'hA000_0004, 1'b1);
      check_eq("stall.stall_cnt", {16'd0, stall_cnt}, 32'd2);
      check_eq("stall.flush_cnt", {16'd0, flush_cnt}, 32'd0);

      // T4 redirects: branch (misaligned target), jump, register jump
      stall = 1'b0; bpc = 32'h43;
      step();
      check_main("br", 32'h40, 32'hC, 32'h0, 1'b0);
      check_eq("br.flush_cnt", {16'd0, flush_cnt}, 32'd1);
      check_eq("br.stall_cnt", {16'd0, stall_cnt}, 32'd2);
      pcsource = 2'b11; jpc = 32'h101;
      step();
      check_main("jmp", 32'h100, 32'h44, 32'h0, 1'b0);
      pcsource = 2'b10; rpc = 32'h40;
      step();
      check_main("jr", 32'h40, 32'h104, 32'h0, 1'b0);
      check_eq("jr.flush_cnt", {16'd0, flush_cnt}, 32'd3);

      // T5 imem wait bubbles, then resume
      pcsource = 2'b00; imem_ready = 1'b0; use_model = 1'b0; rdata_fix = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         step();
         check_main("wait", 32'h40, 32'h104, 32'h0, 1'b0);
      end
      imem_ready = 1'b1; rdata_fix = 32'h1234;
      step();
      check_main("resume", 32'h44, 32'h44, 32'h1234, 1'b1);

      // Redirect flushes even while imem is not ready
      imem_ready = 1'b0; pcsource = 2'b01; bpc = 32'h80;
      step();
      check_main("br_wait", 32'h80, 32'h48, 32'h0, 1'b0);
      check_eq("br_wait.flush_cnt", {16'd0, flush_cnt}, 32'd4);

      // T6 counter saturation and PC wrap on the narrow instance
      clrn2 = 1'b0;
      step();
      check_eq("w.rst_pc", pc2, 32'hFFFF_FFFC);
      clrn2 = 1'b1; stall2 = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check_eq("w.stall_sat", {30'd0, stall_cnt2}, 32'd3);
      check_eq("w.pc_hold", pc2, 32'hFFFF_FFFC);
      stall2 = 1'b0;
      step();
      check_eq("w.pc_wrap", pc2, 32'h0);
      check_eq("w.id_pc4_wrap", id_pc4_2, 32'h0);
      check_eq("w.id_inst", id_inst2, 32'h5555_0000);
      check_eq("w.stall_keep", {30'd0, stall_cnt2}, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
